hicore_de2ex_pipe: RTL
======================

// Module: hicore_de2ex_pipe
// PURPOSE
// - Decode-to-execute pipeline register with a 2-entry skid buffer, in front of the dispatch stage.
// - Decode pushes one packed DE2EX word per valid/ready handshake; dispatch pops from the head.
// - Stall (ready) from dispatch is never combinationally forwarded to decode; the skid entry absorbs one beat.
// - Supports flush on redirect and reports RAW hits of decode's rs1/rs2 against buffered rd writers.
// PARAMETERS
// - INFO_W   `HiCore_DE2EX_SIZE  width of packed decode info word
// - RFIDX_W  `HiCore_RFIDX_WIDTH register index width (5)
// PORTS
// - clk            in   1        core clock, rising edge
// - rst_n          in   1        async active-low reset
// - i_dec_valid    in   1        decode has an instruction
// - i_dec_ready    out  1        pipe accepts (registered: skid entry empty)
// - i_dec_info     in   INFO_W   packed info; [0] nop/except, [4:1] bj/alu/agu/csr sel, [11:7] rd idx, [12] rd need
// - o_de2ex_valid  out  1        head entry valid toward dispatch
// - o_de2ex_ready  in   1        dispatch accepts head
// - o_de2ex_info   out  INFO_W   head entry info
// - i_flush        in   1        redirect: discard all buffered and incoming beats
// - i_rs1_idx      in   RFIDX_W  decode rs1 index for hazard check
// - i_rs2_idx      in   RFIDX_W  decode rs2 index for hazard check
// - o_rs1_hit      out  1        rs1 matches a buffered pending rd
// - o_rs2_hit      out  1        rs2 matches a buffered pending rd
// - o_occupancy    out  2        entries held (0..2)
// BEHAVIOUR
// - Reset: head/skid valid=0, info regs=0; i_dec_ready=1, o_de2ex_valid=0, hits=0, o_occupancy=0.
// - push = i_dec_valid & i_dec_ready & ~i_flush; pop = o_de2ex_valid & o_de2ex_ready.
// - Latency: a pushed beat appears on o_de2ex_* the next cycle when the head is empty or popped that cycle.
// - States (occupancy): EMPTY, HEAD, FULL (head+skid).
//   EMPTY: push -> HEAD (head<=input).
//   HEAD: push&pop -> HEAD (head<=input); push&~pop -> FULL (skid<=input); pop&~push -> EMPTY.
//   FULL: pop -> HEAD (head<=skid); no push possible (ready=0).
// - i_dec_ready = ~skid_valid, registered; deasserts the cycle after entering FULL.
// - Ordering strict FIFO; skid is never bypassed ahead of head.
// - o_de2ex_info held stable while o_de2ex_valid & ~o_de2ex_ready.
// - Flush: next edge clears both valids (-> EMPTY), incoming beat dropped, a concurrent pop still
//   completes downstream; info regs keep old data (don't-care while invalid).
// - Hazard: entry e pending if valid & info[12] & ~info[0]; rsN_hit = OR over entries of
//   (pending & rd==rsN & rsN!=0). Combinational from registers + rs inputs; masked to 0 in flush cycle.
// - Reset mid-operation clears all valids asynchronously; no beat is emitted after rst_n falls.
// - No X propagation: outputs are defined every cycle after reset.
// TESTING
// - Streaming: 8 beats, info=i, dispatch ready=1 -> o_de2ex_info = 0..7 on consecutive cycles,
//   one-cycle latency, i_dec_ready stays 1.
// - Stall: ready=0 while pushing A,B -> occupancy 2, i_dec_ready=0 next cycle; ready=1 -> A then B
//   emitted, i_dec_ready=1 again after A pops.
// - Flush in FULL with i_dec_valid=1 (C) -> next cycle occupancy 0, o_de2ex_valid=0, C never emitted.
// - Hazard: head rd=5 need=1 nop=0, rs1=5, rs2=0 -> rs1_hit=1, rs2_hit=0; same with info[0]=1 -> both 0;
//   rd=0 with rs1=0 -> 0.
// - FULL with pop each cycle and new pushes -> no loss/dup, order preserved across 100 random
//   valid/ready patterns (scoreboard).
// - rst_n low for 1 cycle while FULL -> o_de2ex_valid=0, i_dec_ready=1, occupancy 0 immediately.

Source files
------------

// File: rtl/hicore_de2ex_pipe.sv
// -----------------------------------------------------------------------------
// hicore_de2ex_pipe
//
// Decode-to-execute pipeline register with a two-entry skid buffer. It sits
// between decode and dispatch. Decode pushes one packed DE2EX word per
// valid/ready handshake, and dispatch pops from the head entry. The ready seen
// by decode is derived only from registered state, so a dispatch stall never
// reaches decode combinationally. The skid entry absorbs the one beat that
// decode may already have in flight when the head stalls.
//
// The block also reports read-after-write hazards. It compares decode's rs1
// and rs2 against the rd of every buffered instruction that still has to
// write the register file.
//
// Ports
//   clk            in   1        core clock, rising edge
//   rst_n          in   1        asynchronous active-low reset
//   i_dec_valid    in   1        decode has an instruction
//   i_dec_ready    out  1        pipe accepts a beat (skid entry empty)
//   i_dec_info     in   INFO_W   packed decode info
//                                [0] nop/except, [4:1] unit select,
//                                [11:7] rd index, [12] rd write needed
//   o_de2ex_valid  out  1        head entry valid toward dispatch
//   o_de2ex_ready  in   1        dispatch accepts the head entry
//   o_de2ex_info   out  INFO_W   head entry info
//   i_flush        in   1        redirect: drop buffered and incoming beats
//   i_rs1_idx      in   RFIDX_W  decode rs1 index for the hazard check
//   i_rs2_idx      in   RFIDX_W  decode rs2 index for the hazard check
//   o_rs1_hit      out  1        rs1 matches a buffered pending rd
//   o_rs2_hit      out  1        rs2 matches a buffered pending rd
//   o_occupancy    out  2        number of entries held (0..2)
// -----------------------------------------------------------------------------
module hicore_de2ex_pipe #(
  parameter int INFO_W  = 32,
  parameter int RFIDX_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_dec_valid,
  output logic               i_dec_ready,
  input  logic [INFO_W-1:0]  i_dec_info,
  output logic               o_de2ex_valid,
  input  logic               o_de2ex_ready,
  output logic [INFO_W-1:0]  o_de2ex_info,
  input  logic               i_flush,
  input  logic [RFIDX_W-1:0] i_rs1_idx,
  input  logic [RFIDX_W-1:0] i_rs2_idx,
  output logic               o_rs1_hit,
  output logic               o_rs2_hit,
  output logic [1:0]         o_occupancy
);

  // Field positions inside the packed decode word.
  localparam int NOP_BIT  = 0;
  localparam int RD_LSB   = 7;
  localparam int RDEN_BIT = 12;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HEAD  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [INFO_W-1:0]   r_head_info;
  logic [INFO_W-1:0]   r_skid_info;

  logic w_head_vld;
  logic w_skid_vld;
  logic w_push;
  logic w_pop;
  logic w_ld_head_in;
  logic w_ld_head_skid;
  logic w_ld_skid;

  // An entry is a RAW hazard source when it is valid, really writes rd,
  // is not a nop/exception, and rd matches a nonzero source index
  // (x0 is hardwired, so it never creates a dependency).
  function automatic logic f_rd_hit(
    input logic               vld,
    input logic               rd_need,
    input logic               nop,
    input logic [RFIDX_W-1:0] rd,
    input logic [RFIDX_W-1:0] rs
  );
    f_rd_hit = vld & rd_need & ~nop & (rd == rs) & (rs != '0);
  endfunction

  assign w_head_vld = (r_state != ST_EMPTY);
  assign w_skid_vld = (r_state == ST_FULL);

  // Ready depends only on the state register, never on o_de2ex_ready.
  assign i_dec_ready = ~w_skid_vld;

  assign w_push = i_dec_valid & i_dec_ready & ~i_flush;
  assign w_pop  = w_head_vld & o_de2ex_ready;

  // Next-state and load-enable logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_head_in   = 1'b0;
    w_ld_head_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (i_flush) begin
      // A concurrent pop has already been seen by dispatch this cycle.
      // The info registers keep stale data because they are invalid.
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_nxt  = ST_HEAD;
            w_ld_head_in = 1'b1;
          end
        end
        ST_HEAD: begin
          if (w_push && w_pop) begin
            w_ld_head_in = 1'b1;
          end else if (w_push) begin
            w_state_nxt = ST_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Ready is low here, so no push can arrive. The skid entry
          // advances into the head only after the head leaves.
          if (w_pop) begin
            w_state_nxt    = ST_HEAD;
            w_ld_head_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- head / skid data registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_info <= '0;
      r_skid_info <= '0;
    end else begin
      if (w_ld_head_in) begin
        r_head_info <= i_dec_info;
      end else if (w_ld_head_skid) begin
        r_head_info <= r_skid_info;
      end
      if (w_ld_skid) begin
        r_skid_info <= i_dec_info;
      end
    end
  end

  assign o_de2ex_valid = w_head_vld;
  assign o_de2ex_info  = r_head_info;

  always_comb begin
    o_occupancy = 2'd0;
    case (r_state)
      ST_HEAD: o_occupancy = 2'd1;
      ST_FULL: o_occupancy = 2'd2;
      default: o_occupancy = 2'd0;
    endcase
  end

  // Hazard hits are suppressed while a flush is in progress.
  // Everything buffered is about to be discarded in that cycle.
  assign o_rs1_hit = ~i_flush & (
    f_rd_hit(w_head_vld, r_head_info[RDEN_BIT], r_head_info[NOP_BIT],
             r_head_info[RD_LSB +: RFIDX_W], i_rs1_idx) |
    f_rd_hit(w_skid_vld, r_skid_info[RDEN_BIT], r_skid_info[NOP_BIT],
             r_skid_info[RD_LSB +: RFIDX_W], i_rs1_idx));

  assign o_rs2_hit = ~i_flush & (
    f_rd_hit(w_head_vld, r_head_info[RDEN_BIT], r_head_info[NOP_BIT],
             r_head_info[RD_LSB +: RFIDX_W], i_rs2_idx) |
    f_rd_hit(w_skid_vld, r_skid_info[RDEN_BIT], r_skid_info[NOP_BIT],
             r_skid_info[RD_LSB +: RFIDX_W], i_rs2_idx));

endmodule
